pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core.
- Drives write-enable and flush controls for the PC register and the IF/ID and ID/EX pipeline registers.
- Resolves load-use hazards, taken-branch squashes, instruction-memory wait states and multi-cycle multiply/divide (MDU) stalls.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the datapath. All outputs are consumed by the PC, IF_ID and ID_EX registers in the same cycle.

---
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF_ID / ID_EX enables and flushes for
// load-use, taken-branch, imem wait and multi-cycle MDU hazards, plus a stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_mdu_op,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT - 1);

  state_t     state, state_nx;
  logic [3:0] mdu_cnt, mdu_cnt_nx;
  logic       lu;

  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mdu_busy    = 1'b0;
    state_nx    = state;
    mdu_cnt_nx  = mdu_cnt;
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu) begin
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (id_mdu_op) begin
          pc_we      = 1'b0;
          if_id_we   = 1'b0;
          state_nx   = MDU_WAIT;
          mdu_cnt_nx = MDU_LOAD;
        end else if (!imem_ready) begin
          pc_we       = 1'b0;
          if_id_flush = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_nx    = RUN;
          mdu_cnt_nx  = '0;
        end else begin
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
          mdu_busy    = 1'b1;
          if (mdu_cnt == 4'd0) state_nx = RUN;
          else                 mdu_cnt_nx = mdu_cnt - 4'd1;
        end
      end
      default: state_nx = RUN;
    endcase
    // Reset forces the bubble outputs immediately, independent of any clock edge.
    if (rst) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      mdu_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else begin
      state   <= state_nx;
      mdu_cnt <= mdu_cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (!pc_we && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected controls queued at drive time,
// popped and compared on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 6;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             id_uses_rt = 1'b0, id_mdu_op = 1'b0, ex_mem_read = 1'b0;
  logic             ex_branch_taken = 1'b0, imem_ready = 1'b1;
  logic             pc_we, if_id_we, if_id_flush, id_ex_flush, mdu_busy;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_mdu_op(id_mdu_op),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic pc_we, if_id_we, if_id_flush, id_ex_flush, mdu_busy;
    int   stall;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_vec = 0, n_err = 0;
  int   m_wait = 0;   // MDU wait cycles still owed (0 = running)
  int   m_stall = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("pc_we",        32'(pc_we),        32'(got.pc_we));
      check("if_id_we",     32'(if_id_we),     32'(got.if_id_we));
      check("if_id_flush",  32'(if_id_flush),  32'(got.if_id_flush));
      check("id_ex_flush",  32'(id_ex_flush),  32'(got.id_ex_flush));
      check("mdu_busy",     32'(mdu_busy),     32'(got.mdu_busy));
      check("stall_cycles", 32'(stall_cycles), 32'(got.stall));
    end
  end

  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mdu, input logic mr, input logic [4:0] ert,
                       input logic br, input logic rdy);
    exp_t x;
    logic hz;
    int   nxt;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_mdu_op = mdu;
    ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br; imem_ready = rdy;
    hz = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    x = '{pc_we: 1, if_id_we: 1, if_id_flush: 0, id_ex_flush: 0, mdu_busy: 0, stall: m_stall};
    nxt = m_wait;
    if (m_wait > 0) begin
      if (br) begin
        x.if_id_flush = 1; x.id_ex_flush = 1; nxt = 0;
      end else begin
        x.pc_we = 0; x.if_id_we = 0; x.id_ex_flush = 1; x.mdu_busy = 1; nxt = m_wait - 1;
      end
    end else if (br) begin
      x.if_id_flush = 1; x.id_ex_flush = 1;
    end else if (hz) begin
      x.pc_we = 0; x.if_id_we = 0; x.id_ex_flush = 1;
    end else if (mdu) begin
      x.pc_we = 0; x.if_id_we = 0; nxt = MDU_LAT;
    end else if (!rdy) begin
      x.pc_we = 0; x.if_id_flush = 1;
    end
    sb.push_back(x);
    @(posedge clk);
    if (!x.pc_we && m_stall < SAT) m_stall++;
    m_wait = nxt;
    #1;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_we"},    32'(pc_we),        32'd0);
    check({tag, "_if_id_we"}, 32'(if_id_we),     32'd0);
    check({tag, "_if_flush"}, 32'(if_id_flush),  32'd1);
    check({tag, "_ex_flush"}, 32'(id_ex_flush),  32'd1);
    check({tag, "_busy"},     32'(mdu_busy),     32'd0);
    check({tag, "_stall"},    32'(stall_cycles), 32'd0);
  endtask

  initial begin
    #2 check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(); idle();

    // load-use on rs, then clears once EX holds the bubble
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
    idle();
    check("lu_count", 32'(stall_cycles), 32'd1);

    // rt gating and register 0
    drive(5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
    drive(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
    drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);

    // branch beats lu, mdu and imem wait
    drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);

    // MDU issue + MDU_LAT wait cycles with hazards present but ignored
    drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    repeat (3) idle();
    idle();

    // branch aborts MDU_WAIT
    drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    idle();
    drive(5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    idle();

    // imem wait states
    repeat (3) drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();

    // mixed random traffic
    repeat (60)
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
    repeat (MDU_LAT + 1) idle();

    // asynchronous reset two cycles into MDU_WAIT
    drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(); idle();
    #2 rst = 1'b1;
    #1 check_reset_outputs("arst");
    @(posedge clk); #1;
    rst = 1'b0;
    m_wait = 0; m_stall = 0;
    idle(); idle();

    // stall counter saturation
    repeat (SAT + 6) drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("stall_sat", 32'(stall_cycles), 32'(SAT));
    idle();
    @(negedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
